pc_branch_ctrl: RTL and testbench

//  Program-counter and branch-resolution stage that consumes the 3-bit {Z,V,N} flag register output.

---
 rtl/pc_branch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// PC register, B/BR condition resolution and RUN/HALTED control.
// Optional branch statistics counters: define PC_BRANCH_STATS_EN.
module pc_branch_ctrl #(
    parameter int              PC_W     = 16,
    parameter int              IMM_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [3:0]       opcode,
    input  logic [2:0]       ccc,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  rs_data,
    input  logic [2:0]       flag,
`ifdef PC_BRANCH_STATS_EN
    output logic [15:0]      br_count,
    output logic [15:0]      br_taken_count,
`endif
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  pc_plus2,
    output logic             branch_taken,
    output logic             flush,
    output logic             halted
);

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [PC_W-1:0] b_off;
    logic            z, v, n;
    logic            cond;
    logic            accept;
    logic            is_br;

    assign z = flag[2];
    assign v = flag[1];
    assign n = flag[0];

    always_comb begin
        cond = 1'b0;
        unique case (ccc)
            3'b000: cond = !z;
            3'b001: cond = z;
            3'b010: cond = !z && !n;
            3'b011: cond = n;
            3'b100: cond = z || (!z && !n);
            3'b101: cond = n || z;
            3'b110: cond = v;
            3'b111: cond = 1'b1;
        endcase
    end

    // word offset scaled to bytes
    assign b_off    = {{(PC_W-IMM_W-1){imm[IMM_W-1]}}, imm, 1'b0};
    assign pc_plus2 = pc_q + PC_W'(2);
    assign pc_out   = pc_q;
    assign accept   = (state == RUN) && !stall;
    assign is_br    = (opcode == OP_B) || (opcode == OP_BR);

    assign branch_taken = is_br && cond && accept;

    always_comb begin
        pc_nxt = pc_plus2;
        if (branch_taken)
            pc_nxt = (opcode == OP_B) ? pc_plus2 + b_off : rs_data;
        else if (opcode == OP_HLT)
            pc_nxt = pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            pc_q  <= RESET_PC;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            flush <= branch_taken;
            if (accept)
                pc_q <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (accept && opcode == OP_HLT) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        halted = (state == HALTED);
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (accept && is_br) begin
            if (br_count != 16'hFFFF)
                br_count <= br_count + 16'd1;
            if (cond && br_taken_count != 16'hFFFF)
                br_taken_count <= br_taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed testbench for pc_branch_ctrl.
// Define PC_BRANCH_STATS_EN to also check the branch counters.
module tb_pc_branch_ctrl;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  opcode = OP_NOP;
    logic [2:0]  ccc = 3'b000;
    logic [8:0]  imm = 9'h000;
    logic [15:0] rs_data = 16'h0000;
    logic [2:0]  flag = 3'b000;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        branch_taken;
    logic        flush;
    logic        halted;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken_count;
`endif

    int errors = 0;
    int checks = 0;

    pc_branch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .opcode       (opcode),
        .ccc          (ccc),
        .imm          (imm),
        .rs_data      (rs_data),
        .flag         (flag),
`ifdef PC_BRANCH_STATS_EN
        .br_count      (br_count),
        .br_taken_count(br_taken_count),
`endif
        .pc_out       (pc_out),
        .pc_plus2     (pc_plus2),
        .branch_taken (branch_taken),
        .flush        (flush),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [2:0] c,
                          input logic [8:0] i, input logic [15:0] r,
                          input logic [2:0] f);
        opcode  = op;
        ccc     = c;
        imm     = i;
        rs_data = r;
        flag    = f;
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        set_op(OP_BR, 3'b111, 9'h000, v, 3'b000);
        cyc();
        set_op(OP_NOP, 3'b000, 9'h000, 16'h0000, 3'b000);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_pc", 32'(pc_out), 32'h0000);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_pc2", 32'(pc_plus2), 32'h0002);
        #10 rst = 1'b1;

        // sequential fetch
        cyc();
        chk("seq_pc1", 32'(pc_out), 32'h0002);
        cyc();
        chk("seq_pc2", 32'(pc_out), 32'h0004);
        cyc();
        chk("seq_pc3", 32'(pc_out), 32'h0006);
        chk("seq_flush", 32'(flush), 32'h0);
        chk("seq_halted", 32'(halted), 32'h0);

        // B EQ taken
        load_pc(16'h0010);
        chk("load_pc", 32'(pc_out), 32'h0010);
        chk("load_flush", 32'(flush), 32'h1);
        set_op(OP_B, 3'b001, 9'h004, 16'h0000, 3'b100);
        chk("beq_taken", 32'(branch_taken), 32'h1);
        cyc();
        chk("beq_pc", 32'(pc_out), 32'h001A);
        chk("beq_flush", 32'(flush), 32'h1);
        set_op(OP_NOP, 3'b000, 9'h000, 16'h0000, 3'b000);
        cyc();
        chk("beq_flush_end", 32'(flush), 32'h0);
        chk("nop_pc", 32'(pc_out), 32'h001C);

        // B GT not taken with N=1
        load_pc(16'h0010);
        set_op(OP_B, 3'b010, 9'h004, 16'h0000, 3'b001);
        chk("bgt_nt", 32'(branch_taken), 32'h0);
        cyc();
        chk("bgt_pc", 32'(pc_out), 32'h0012);
        chk("bgt_flush", 32'(flush), 32'h0);

        // B UN self-loop with imm=-1
        load_pc(16'h0010);
        set_op(OP_B, 3'b111, 9'h1FF, 16'h0000, 3'b000);
        cyc();
        chk("bun_loop_pc", 32'(pc_out), 32'h0010);

        // remaining conditions, combinational only
        set_op(OP_B, 3'b000, 9'h000, 16'h0000, 3'b100);
        chk("bne_z1", 32'(branch_taken), 32'h0);
        set_op(OP_B, 3'b011, 9'h000, 16'h0000, 3'b001);
        chk("blt_n1", 32'(branch_taken), 32'h1);
        set_op(OP_B, 3'b100, 9'h000, 16'h0000, 3'b000);
        chk("bge_000", 32'(branch_taken), 32'h1);
        set_op(OP_B, 3'b100, 9'h000, 16'h0000, 3'b001);
        chk("bge_n1", 32'(branch_taken), 32'h0);
        set_op(OP_B, 3'b101, 9'h000, 16'h0000, 3'b000);
        chk("ble_000", 32'(branch_taken), 32'h0);
        set_op(OP_B, 3'b110, 9'h000, 16'h0000, 3'b101);
        chk("bov_v0", 32'(branch_taken), 32'h0);
        set_op(OP_NOP, 3'b111, 9'h000, 16'h0000, 3'b000);
        chk("nop_un", 32'(branch_taken), 32'h0);

        // BR OV under stall, then released
        set_op(OP_BR, 3'b110, 9'h000, 16'h1234, 3'b010);
        stall = 1'b1;
        #1;
        chk("br_stall_bt", 32'(branch_taken), 32'h0);
        cyc();
        chk("br_stall_pc1", 32'(pc_out), 32'h0010);
        chk("br_stall_fl1", 32'(flush), 32'h0);
        cyc();
        chk("br_stall_pc2", 32'(pc_out), 32'h0010);
        stall = 1'b0;
        #1;
        chk("br_rel_bt", 32'(branch_taken), 32'h1);
        cyc();
        chk("br_pc", 32'(pc_out), 32'h1234);
        chk("br_flush", 32'(flush), 32'h1);

        // HLT freezes PC
        load_pc(16'h0020);
        set_op(OP_HLT, 3'b000, 9'h000, 16'h0000, 3'b000);
        cyc();
        chk("hlt_halted", 32'(halted), 32'h1);
        chk("hlt_pc", 32'(pc_out), 32'h0020);
        set_op(OP_B, 3'b111, 9'h010, 16'h0000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            if (branch_taken !== 1'b0 || flush !== 1'b0)
                chk("halt_bt_flush", {30'h0, branch_taken, flush}, 32'h0);
            cyc();
        end
        chk("halt_pc_10", 32'(pc_out), 32'h0020);
        chk("halt_still", 32'(halted), 32'h1);
        chk("halt_bt", 32'(branch_taken), 32'h0);

        // async reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_pc", 32'(pc_out), 32'h0000);
        chk("arst_halted", 32'(halted), 32'h0);
        set_op(OP_NOP, 3'b000, 9'h000, 16'h0000, 3'b000);
        rst = 1'b1;
        cyc();
        chk("arst_first", 32'(pc_out), 32'h0002);

        // wrap
        load_pc(16'hFFFE);
        chk("wrap_pc2", 32'(pc_plus2), 32'h0000);
        cyc();
        chk("wrap_pc", 32'(pc_out), 32'h0000);

`ifdef PC_BRANCH_STATS_EN
        #2 rst = 1'b0;
        #1;
        chk("st_rst", {br_count, br_taken_count}, 32'h0);
        rst = 1'b1;
        cyc();
        set_op(OP_B, 3'b111, 9'h000, 16'h0000, 3'b000);
        cyc();
        set_op(OP_B, 3'b001, 9'h000, 16'h0000, 3'b000);
        cyc();
        set_op(OP_B, 3'b000, 9'h000, 16'h0000, 3'b000);
        stall = 1'b1;
        cyc();
        stall = 1'b0;
        cyc();
        set_op(OP_B, 3'b110, 9'h000, 16'h0000, 3'b000);
        cyc();
        set_op(OP_BR, 3'b111, 9'h000, 16'h0040, 3'b000);
        cyc();
        set_op(OP_NOP, 3'b000, 9'h000, 16'h0000, 3'b000);
        cyc();
        chk("st_count", 32'(br_count), 32'd5);
        chk("st_taken", 32'(br_taken_count), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
